// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: turns the 1 Hz divider strobe into off / solid / blink /
// counted-burst patterns on the board LED, with 4-bit PWM brightness.
module led_pattern_ctrl #(
    parameter int PWM_PERIOD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [1:0] mode,
    input  logic [3:0] brightness,
    input  logic       start,
    input  logic [3:0] burst_len,
    output logic       led,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(PWM_PERIOD);

    typedef enum logic [2:0] {
        S_OFF,
        S_SOLID,
        S_BLINK_ON,
        S_BLINK_OFF,
        S_BURST_IDLE,
        S_BURST_ON,
        S_BURST_OFF
    } state_t;

    state_t        state, state_n;
    logic [3:0]    burst_cnt, cnt_n;
    logic [PW-1:0] pwm_cnt;
    logic          done_n;
    logic          busy_n;
    logic          phase_on;
    logic          pwm_hit;

    // Mode that each state belongs to; a mismatch with the mode input is a mode change.
    function automatic logic [1:0] state_mode(input state_t s);
        case (s)
            S_SOLID:                                state_mode = 2'b01;
            S_BLINK_ON, S_BLINK_OFF:                state_mode = 2'b10;
            S_BURST_IDLE, S_BURST_ON, S_BURST_OFF:  state_mode = 2'b11;
            default:                                state_mode = 2'b00;
        endcase
    endfunction

    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip an assignment infer latches.
    always_comb begin
        state_n = state;
        cnt_n   = burst_cnt;
        done_n  = 1'b0;
        if (mode != state_mode(state)) begin
            cnt_n = '0;
            unique case (mode)
                2'b00:   state_n = S_OFF;
                2'b01:   state_n = S_SOLID;
                2'b10:   state_n = S_BLINK_ON;
                default: state_n = S_BURST_IDLE;
            endcase
        end else begin
            case (state)
                S_BLINK_ON:  if (tick) state_n = S_BLINK_OFF;
                S_BLINK_OFF: if (tick) state_n = S_BLINK_ON;
                S_BURST_IDLE: begin
                    // start has priority; a coincident tick is simply not counted
                    if (start) begin
                        if (burst_len != 4'd0) begin
                            cnt_n   = burst_len;
                            state_n = S_BURST_ON;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                S_BURST_ON: if (tick) state_n = S_BURST_OFF;
                S_BURST_OFF: begin
                    if (tick) begin
                        if (burst_cnt == 4'd1) begin
                            cnt_n   = '0;
                            state_n = S_BURST_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            cnt_n   = burst_cnt - 4'd1;
                            state_n = S_BURST_ON;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase_on = (state == S_SOLID) || (state == S_BLINK_ON) || (state == S_BURST_ON);
    assign busy_n   = (state_n == S_BURST_ON) || (state_n == S_BURST_OFF);
    assign pwm_hit  = (32'(pwm_cnt) < 32'(brightness));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            burst_cnt <= '0;
            pwm_cnt   <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            burst_cnt <= cnt_n;
            pwm_cnt   <= (pwm_cnt == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 1'b1;
            led       <= phase_on & pwm_hit;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: a behavioural model predicts led/busy/done
// per clock edge, a separate monitor pops and compares after each edge.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] brightness = 4'd0;
    logic       start = 1'b0;
    logic [3:0] burst_len = 4'd0;
    logic       led, busy, done;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.PWM_PERIOD(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .mode       (mode),
        .brightness (brightness),
        .start      (start),
        .burst_len  (burst_len),
        .led        (led),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic led;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   fail_prints = 0;

    // Model: remembers the selected mode, the blink phase and the number of ticks
    // left in a burst (2L at start; the LED is lit while an even number remain).
    logic [1:0] m_mode;
    logic       m_lit;
    int         m_left;
    int         m_pwm;
    logic       last_tick;
    logic       last_led;

    // Observation counters maintained by the monitor.
    int led_rises, done_cnt, busy_cnt, led_hi;
    logic led_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
            end
        end
    endtask

    function automatic logic model_phase_on();
        case (m_mode)
            2'b01:   return 1'b1;
            2'b10:   return m_lit;
            2'b11:   return (m_left != 0) && (m_left % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode    = 2'b00;
        m_lit     = 1'b0;
        m_left    = 0;
        m_pwm     = 0;
        last_tick = 1'b0;
        last_led  = 1'b0;
    endtask

    // Called just after a falling edge: drive inputs, predict the next rising edge.
    task automatic step(input bit tk, input bit st);
        exp_t e;
        if (tk && last_tick) tk = 1'b0;  // never hold tick for two cycles
        tick      = tk;
        start     = st;
        last_tick = tk;
        e.led  = model_phase_on() && (m_pwm < int'(brightness));
        e.done = 1'b0;
        m_pwm  = (m_pwm + 1) % 15;
        if (mode != m_mode) begin
            m_mode = mode;
            m_lit  = (mode == 2'b10);
            m_left = 0;
        end else if (mode == 2'b10) begin
            if (tk) m_lit = !m_lit;
        end else if (mode == 2'b11) begin
            if (m_left == 0) begin
                if (st) begin
                    if (burst_len != 4'd0) m_left = 2 * int'(burst_len);
                    else e.done = 1'b1;
                end
            end else if (tk) begin
                m_left--;
                if (m_left == 0) e.done = 1'b1;
            end
        end
        e.busy   = (m_left != 0);
        last_led = e.led;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++)
            step((period > 0) && ((i % period) == period - 1), 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        #1;
        check("rst_led_immediate", led, 0);
        check("rst_busy_immediate", busy, 0);
        check("rst_done_immediate", done, 0);
        model_reset();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(3'b000);
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic clear_counters();
        led_rises = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
        led_hi    = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("led", led, e.led);
                check("busy", busy, e.busy);
                check("done", done, e.done);
                if (led && !led_q) led_rises++;
                if (done) done_cnt++;
                if (busy) busy_cnt++;
                if (led) led_hi++;
                led_q = led;
            end
        end
    end

    initial begin : stimulus
        int n;
        model_reset();
        clear_counters();
        @(negedge clk);
        do_reset(3);

        // Off: LED must stay dark for 100 cycles.
        mode = 2'b00;
        clear_counters();
        run(100, 0);
        check("off_led_hi", led_hi, 0);

        // Solid PWM at 5/15, then full and zero brightness.
        mode = 2'b01;
        brightness = 4'd5;
        run(3, 0);
        clear_counters();
        run(30, 0);
        check("solid5_duty", led_hi, 10);
        brightness = 4'd15;
        run(2, 0);
        clear_counters();
        run(20, 0);
        check("solid15_duty", led_hi, 20);
        brightness = 4'd0;
        run(2, 0);
        clear_counters();
        run(20, 0);
        check("solid0_duty", led_hi, 0);

        // Blink: 10 ticks, 20 cycles apart, full brightness.
        mode = 2'b10;
        brightness = 4'd15;
        run(2, 0);
        run(200, 20);

        // Asynchronous reset while the LED is lit.
        n = 0;
        while (!last_led && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("led_before_reset", led, 1);
        do_reset(3);
        mode = 2'b00;
        run(5, 0);

        // Burst of 3 with a second start ignored mid-burst.
        mode = 2'b11;
        burst_len = 4'd3;
        run(3, 0);
        clear_counters();
        step(1'b0, 1'b1);
        check("burst_busy_after_start", busy, 1);
        run(25, 10);
        step(1'b0, 1'b1);
        run(50, 10);
        check("burst_pulses", led_rises, 3);
        check("burst_done_count", done_cnt, 1);

        // Zero-length burst.
        burst_len = 4'd0;
        clear_counters();
        step(1'b0, 1'b1);
        check("len0_done_next", done, 1);
        run(10, 3);
        check("len0_busy_cycles", busy_cnt, 0);
        check("len0_led_hi", led_hi, 0);
        check("len0_done_count", done_cnt, 1);

        // start coincident with tick: the tick is not counted.
        burst_len = 4'd3;
        run(3, 0);
        clear_counters();
        step(1'b1, 1'b1);
        run(70, 10);
        check("coincident_pulses", led_rises, 3);
        check("coincident_done_count", done_cnt, 1);

        // Abort: switch to solid after three ticks of a 4-pair burst.
        burst_len = 4'd4;
        brightness = 4'd7;
        run(2, 0);
        clear_counters();
        step(1'b0, 1'b1);
        run(30, 10);
        mode = 2'b01;
        step(1'b0, 1'b0);
        check("abort_busy_drop", busy, 0);
        run(40, 0);
        check("abort_done_count", done_cnt, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(59) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(99) == 0) brightness = 4'($urandom_range(15));
            burst_len = ($urandom_range(4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            step($urandom_range(7) == 0, $urandom_range(19) == 0);
        end

        // Drain the scoreboard with a bounded wait.
        tick = 1'b0;
        start = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Downstream consumer of the 1 Hz divider strobe: turns the one-cycle `tick` into a visible LED pattern on the board LED. It supports off, solid, blink and counted-burst modes, with 4-bit PWM brightness. It sits between the clock divider (which supplies `tick`) and the LED pin, and replaces the bare toggle flop in the top level.

## Interface
- `PWM_PERIOD`, 15: PWM period in clk cycles. Fixed so that brightness 15 means 100% duty.
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `tick`  in  1  one-clk strobe from the upstream divider; one pattern phase per tick
- `mode`  in  2  00 off, 01 solid, 10 blink, 11 burst
- `brightness`  in  4  PWM duty in fifteenths; 0 = dark, 15 = fully on
- `start`  in  1  one-clk pulse; arms a burst in mode 11
- `burst_len`  in  4  number of on/off pairs per burst; sampled on the start cycle
- `led`  out  1  registered LED drive
- `busy`  out  1  high while a burst is running
- `done`  out  1  one-clk pulse when a burst completes normally

## Operation
- Reset values: state OFF, `led`=0, `busy`=0, `done`=0, PWM counter 0, burst counter 0.
- PWM counter is free-running 0..14 and wraps to 0. `pwm_hit` = (counter < `brightness`). `brightness`=15 is always hit; 0 is never hit.
- `phase_on` is decoded from state. `led` <= `phase_on` & `pwm_hit`.
- States: OFF, SOLID, BLINK_ON, BLINK_OFF, BURST_IDLE, BURST_ON, BURST_OFF.
- Mode select, evaluated every cycle; a change of `mode` forces the entry state on the next edge:
  - 00 → OFF
  - 01 → SOLID
  - 10 → BLINK_ON
  - 11 → BURST_IDLE
- OFF, BURST_IDLE: `phase_on`=0.
- SOLID: `phase_on`=1. `tick` is ignored.
- BLINK_ON ↔ BLINK_OFF: toggles on each `tick`.
- BURST_IDLE + `start`:
  - `burst_len`≠0: load counter with `burst_len`, go to BURST_ON.
  - `burst_len`=0: stay in BURST_IDLE and pulse `done` on the next cycle. No LED activity.
- BURST_ON + `tick` → BURST_OFF.
- BURST_OFF + `tick`:
  - counter=1: → BURST_IDLE, pulse `done`.
  - otherwise: decrement counter, → BURST_ON.
- `busy` = state ∈ {BURST_ON, BURST_OFF}, registered.
- `start` while busy, or outside mode 11, is ignored.
- Mode change mid-burst aborts the burst: no `done`, `busy` drops, counter is cleared.
- `start` and `tick` in the same cycle in BURST_IDLE: `start` wins and the tick is not counted. The first ON phase lasts until the next tick.
- `tick` held high for several cycles is a protocol violation; behaviour is unspecified.

## Timing
- State updates on the edge that samples `tick`, `start` or a `mode` change.
- `led` follows state with one more register, giving 2-edge latency from the sampling edge to `led`.
- `done` and `busy` are registered in the same cycle as the state change, giving 1-edge latency.
- First phase after entering BLINK or BURST is partial: from entry to the next tick, 0..N cycles.
- Full burst of length L takes exactly 2L ticks from the first tick after start. `done` is asserted on the edge sampling the 2L-th tick.
- Asserting `rst_n` at any time immediately clears all outputs. Deassertion is synchronized externally.

## Test plan
- Reset: assert `rst_n`=0 mid-blink with `led`=1 → `led`, `busy`, `done` go 0 immediately. After release, mode 00 holds `led`=0 for 100 cycles.
- Solid PWM: mode 01, `brightness`=5, no ticks → `led` high exactly 5 of every 15 cycles. `brightness`=15 → constant 1; 0 → constant 0.
- Blink: mode 10, `brightness`=15, tick every 20 cycles → `led` toggles 2 edges after each tick. 10 ticks give 5 high and 5 low phases.
- Burst: mode 11, `burst_len`=3, start, tick every 10 cycles:
  - `busy` rises 1 edge after start.
  - Exactly 3 high pulses appear on `led`.
  - `done` pulses once on the 6th tick; `busy` falls in the same cycle.
  - A second start during the burst is ignored.
- Edge cases:
  - `burst_len`=0 with start → `done` pulse next cycle, `busy` never high, `led` stays 0.
  - `start` coincident with `tick` → the tick is not counted; still 3 pulses for `burst_len`=3.
- Abort: mode 11 burst with `burst_len`=4; switch `mode` to 01 after 3 ticks → `busy`=0 next edge, no `done`, `led` follows solid PWM 2 edges later.
